key_press_classifier: RTL
=========================

KEY_PRESS_CLASSIFIER -- requirements
Module: key_press_classifier

Interface
REQ-001 Parameter LONG_CNT, default 50_000_000, is the hold length in I_clk cycles that classifies a press as long (1 s at 50 MHz).
REQ-002 Parameter GAP_CNT, default 15_000_000, is the maximum released gap in cycles for a double click (300 ms).
REQ-003 Parameter PRESS_LEVEL, default 1'b0, is the I_key level that means "pressed".
REQ-004 The block SHALL use clock I_clk; reset I_rst_n is asynchronous and active-low.
REQ-005 Port I_clk, input, 1 bit: system clock.
REQ-006 Port I_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port I_key, input, 1 bit: key level, already debounced and synchronous to I_clk (output of the key debouncer).
REQ-008 Port o_evt_valid, output, 1 bit: one-cycle event strobe.
REQ-009 Port o_evt_code, output, 2 bits: event code, valid only while o_evt_valid=1.
REQ-010 Port o_pressed, output, 1 bit: registered "key currently pressed" level.

Function
REQ-011 Event codes SHALL be NONE=2'b00, SHORT=2'b01, LONG=2'b10, DOUBLE=2'b11.
REQ-012 key_d SHALL be a one-cycle registered copy of I_key.
- press edge: I_key==PRESS_LEVEL and key_d!=PRESS_LEVEL.
- release edge: the inverse condition.
REQ-013 An armed flag SHALL clear on reset and set on the first cycle I_key!=PRESS_LEVEL.
- No edge is acted on while the flag is clear, so a debouncer reset value equal to PRESS_LEVEL never creates an event.
REQ-014 FSM states SHALL be IDLE, PRESS1, GAP and WAIT_REL.
- A 26-bit counter clears on every state entry and increments by 1 each cycle in PRESS1 and GAP.
- The counter saturates at all-ones.
REQ-015 IDLE: armed and press edge -> PRESS1.
REQ-016 PRESS1: release edge with cnt < LONG_CNT-1 -> GAP.
REQ-017 PRESS1: still pressed with cnt==LONG_CNT-1 -> emit LONG, go to WAIT_REL.
REQ-018 GAP: press edge with cnt < GAP_CNT-1 -> emit DOUBLE, go to WAIT_REL.
REQ-019 GAP: cnt==GAP_CNT-1 with no press -> emit SHORT, go to IDLE.
REQ-020 WAIT_REL: release edge -> IDLE, with no event.
REQ-021 "Emit" SHALL mean o_evt_valid=1 and o_evt_code=code for exactly the one cycle after the clock edge that sampled the condition; otherwise o_evt_valid=0 and o_evt_code=NONE.
REQ-022 Simultaneous events SHALL resolve as follows:
- release in the same cycle as cnt==LONG_CNT-1 in PRESS1: release wins, go to GAP.
- press in the same cycle as cnt==GAP_CNT-1 in GAP: press wins, emit DOUBLE.
REQ-023 At most one event SHALL be emitted per press sequence; events are never queued.
REQ-024 o_pressed SHALL equal (key_d==PRESS_LEVEL) and armed, i.e. one cycle of latency.
REQ-025 Parameter values below 2 are illegal; behaviour for them is undefined.

Reset
REQ-026 On I_rst_n=0 the block SHALL asynchronously force:
- state=IDLE, cnt=0, armed=0, key_d=PRESS_LEVEL;
- o_evt_valid=0, o_evt_code=2'b00, o_pressed=0.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence with no event emitted after reset release.

Configuration
REQ-028 With macro KEY_DOUBLE_CLICK_EN defined, the block SHALL behave as REQ-014..REQ-022.
REQ-029 Without KEY_DOUBLE_CLICK_EN, the block SHALL omit the GAP state and its GAP_CNT logic.
- PRESS1 release edge -> emit SHORT, go to IDLE.
- DOUBLE is never emitted.

Structure
REQ-030 Package key_pkg SHALL hold:
- the event-code constants;
- the FSM state typedef;
- the counter width constant (26).
REQ-031 Edge detection and arming SHALL live in sub-module key_edge_det.
- outputs: press_edge, release_edge, level, armed.
- it is instantiated once; the FSM and counter stay in the top.

Verification (bench uses LONG_CNT=20, GAP_CNT=10, PRESS_LEVEL=0)
REQ-032 Short press: hold I_key=0 for 5 cycles, release, idle 15 cycles -> exactly one o_evt_valid pulse, code 01, 10 cycles after the release edge.
REQ-033 Long press: hold I_key=0 for 30 cycles -> code 10, 20 cycles after the press edge; no event at release.
REQ-034 Double click: press 4 cycles, release 3 cycles, press again -> code 11 one cycle after the second press edge; no further event at its release.
REQ-035 Boundaries:
- release in exactly the cycle cnt==19 -> no LONG; SHORT follows the gap.
- second press in the cycle cnt==9 of GAP -> DOUBLE, not SHORT.
REQ-036 Reset and arming:
- hold I_key=0 through reset release -> no event and o_pressed=0 until I_key=1 is seen.
- assert I_rst_n=0 in the middle of PRESS1 -> all outputs 0 immediately and no event afterwards.
REQ-037 Rebuild without KEY_DOUBLE_CLICK_EN and repeat REQ-032/REQ-034 stimulus -> code 01 one cycle after each release edge; code 11 never appears.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types for the key press classifier: event codes, FSM states, counter width.
// Latency: n/a (types only). Backpressure: n/a. GAP state exists only with KEY_DOUBLE_CLICK_EN.
package key_pkg;

    localparam int CNT_W = 26;

    typedef logic [1:0] evt_code_t;

    localparam evt_code_t EVT_NONE   = 2'b00;
    localparam evt_code_t EVT_SHORT  = 2'b01;
    localparam evt_code_t EVT_LONG   = 2'b10;
    localparam evt_code_t EVT_DOUBLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS1   = 2'd1,
        ST_WAIT_REL = 2'd2
`ifdef KEY_DOUBLE_CLICK_EN
        ,
        ST_GAP      = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/key_press_classifier_if.sv
// Event/status bundle from the key press classifier to its consumer.
// Latency: n/a (wires). Backpressure: none, events are single-cycle strobes.
interface key_press_classifier_if;
    logic                o_evt_valid;
    key_pkg::evt_code_t  o_evt_code;
    logic                o_pressed;

    modport master (output o_evt_valid, output o_evt_code, output o_pressed);
    modport slave  (input  o_evt_valid, input  o_evt_code, input  o_pressed);
endinterface

// File: rtl/key_edge_det.sv
// Press/release edge detector with arming; edges are combinational from I_key and key_d.
// Latency: edges same cycle, level one cycle. Backpressure: none.
module key_edge_det #(
    parameter logic PRESS_LEVEL = 1'b0
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_key,
    output logic press_edge,
    output logic release_edge,
    output logic level,
    output logic armed
);

    logic key_d_q, key_d_d;
    logic armed_q, armed_d;

    // Arming waits for a released level so a key held through reset never fires.
    always_comb begin
        key_d_d = I_key;
        armed_d = armed_q | (I_key != PRESS_LEVEL);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            key_d_q <= PRESS_LEVEL;
            armed_q <= 1'b0;
        end else begin
            key_d_q <= key_d_d;
            armed_q <= armed_d;
        end
    end

    assign press_edge   = armed_q & (I_key == PRESS_LEVEL) & (key_d_q != PRESS_LEVEL);
    assign release_edge = armed_q & (I_key != PRESS_LEVEL) & (key_d_q == PRESS_LEVEL);
    assign level        = (key_d_q == PRESS_LEVEL);
    assign armed        = armed_q;

endmodule

// File: rtl/key_press_classifier.sv
// Classifies debounced key presses into SHORT / LONG / DOUBLE (DOUBLE needs KEY_DOUBLE_CLICK_EN).
// Latency: event strobe one cycle after the deciding edge. Backpressure: none, events never queue.
module key_press_classifier import key_pkg::*; #(
    parameter int unsigned LONG_CNT    = 50_000_000,
    parameter int unsigned GAP_CNT     = 15_000_000,
    parameter logic        PRESS_LEVEL = 1'b0
) (
    input  logic                   I_clk,
    input  logic                   I_rst_n,
    input  logic                   I_key,
    key_press_classifier_if.master evt
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
`ifdef KEY_DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);
`endif

    generate
        if (LONG_CNT < 2 || GAP_CNT < 2) begin : g_bad_params
            $error("key_press_classifier: LONG_CNT and GAP_CNT must be >= 2");
        end
    endgenerate

    logic press_edge, release_edge, level, armed;

    key_edge_det #(.PRESS_LEVEL(PRESS_LEVEL)) u_edge (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_key       (I_key),
        .press_edge  (press_edge),
        .release_edge(release_edge),
        .level       (level),
        .armed       (armed)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_vld_q, evt_vld_d;
    evt_code_t        evt_code_q, evt_code_d;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            evt_vld_q  <= 1'b0;
            evt_code_q <= EVT_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            evt_vld_q  <= evt_vld_d;
            evt_code_q <= evt_code_d;
        end
    end

    // Release beats the long timeout; a second press beats the gap timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (press_edge) state_d = ST_PRESS1;
            ST_PRESS1: begin
                if (release_edge) begin
`ifdef KEY_DOUBLE_CLICK_EN
                    state_d = ST_GAP;
`else
                    state_d = ST_IDLE;
`endif
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_WAIT_REL;
                end
            end
`ifdef KEY_DOUBLE_CLICK_EN
            ST_GAP: begin
                if (press_edge)              state_d = ST_WAIT_REL;
                else if (cnt_q == GAP_LAST)  state_d = ST_IDLE;
            end
`endif
            ST_WAIT_REL: if (release_edge) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        evt_vld_d  = 1'b0;
        evt_code_d = EVT_NONE;
        case (state_q)
            ST_PRESS1: begin
                if (release_edge) begin
`ifndef KEY_DOUBLE_CLICK_EN
                    evt_vld_d  = 1'b1;
                    evt_code_d = EVT_SHORT;
`endif
                end else if (cnt_q == LONG_LAST) begin
                    evt_vld_d  = 1'b1;
                    evt_code_d = EVT_LONG;
                end
            end
`ifdef KEY_DOUBLE_CLICK_EN
            ST_GAP: begin
                if (press_edge) begin
                    evt_vld_d  = 1'b1;
                    evt_code_d = EVT_DOUBLE;
                end else if (cnt_q == GAP_LAST) begin
                    evt_vld_d  = 1'b1;
                    evt_code_d = EVT_SHORT;
                end
            end
`endif
            default: ;
        endcase

        // Counter restarts on every state entry and saturates at all-ones.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_PRESS1
`ifdef KEY_DOUBLE_CLICK_EN
                      || state_q == ST_GAP
`endif
                     ) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign evt.o_evt_valid = evt_vld_q;
    assign evt.o_evt_code  = evt_code_q;
    assign evt.o_pressed   = level & armed;

endmodule
